mux_scan_ctrl: RTL and testbench

- Sequencer for the 16:1 word/select multiplexer datapath.
- On a start pulse it captures a 16-bit data word and a channel-enable mask.
- It then walks the select through every enabled channel, lowest index first, presenting one selected bit per cycle with a valid strobe.
- It counts the ones seen and signals completion with a one-cycle done pulse.
- It sits between a host issuing scan requests and the mux, which it drives through sel.

---
 rtl/mux_scan_ctrl.sv | 109 ++++++++++
 tb/tb_mux_scan_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for the 16:1 word/select mux. It captures a word and a channel mask,
// steps sel through the enabled channels in ascending order, counts the ones, and pulses done.
module mux_scan_ctrl #(
    parameter int WIDTH = 16,
    parameter int SEL_W = 4,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] w,
    input  logic [WIDTH-1:0] mask,
    input  logic             hold,
    output logic [SEL_W-1:0] sel,
    output logic             f,
    output logic             f_valid,
    output logic             busy,
    output logic [CNT_W-1:0] ones,
    output logic             done,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] w_reg;
    logic [WIDTH-1:0] mask_reg;
    logic [SEL_W-1:0] first_sel;
    logic [SEL_W-1:0] next_sel;
    logic             next_found;

    // Lowest enabled channel of the incoming mask; the descending loop lets the lowest index win.
    always_comb begin
        first_sel = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                first_sel = SEL_W'(i);
            end
        end
    end

    // Lowest enabled channel strictly above sel. When no such channel exists, the scan is complete.
    always_comb begin
        next_sel   = sel;
        next_found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (mask_reg[i] && (i > int'(sel))) begin
                next_sel   = SEL_W'(i);
                next_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            sel      <= '0;
            ones     <= '0;
            w_reg    <= '0;
            mask_reg <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        w_reg    <= w;
                        mask_reg <= mask;
                        ones     <= '0;
                        if (|mask) begin
                            sel   <= first_sel;
                            state <= SCAN;
                        end else begin
                            sel   <= '0;
                            state <= DONE;
                        end
                    end else begin
                        sel   <= '0;
                        state <= IDLE;
                    end
                end
                SCAN: begin
                    if (!hold) begin
                        ones <= ones + CNT_W'(f);
                        if (next_found) begin
                            sel <= next_sel;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // A sample is valid on every SCAN cycle that is not stalled.
    // f is forced to 0 whenever the FSM is outside SCAN.
    assign busy      = (state == SCAN);
    assign done      = (state == DONE);
    assign f         = busy & w_reg[sel];
    assign f_valid   = busy & ~hold;
    assign state_dbg = state;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl. Table-driven scans use an expected-sample queue,
// followed by hand-written sequences for back-to-back starts and a mid-scan reset.
module tb_mux_scan_ctrl;
    localparam int WIDTH = 16;
    localparam int SEL_W = 4;
    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             hold = 1'b0;
    logic [WIDTH-1:0] w = '0;
    logic [WIDTH-1:0] mask = '0;
    logic [SEL_W-1:0] sel;
    logic             f;
    logic             f_valid;
    logic             busy;
    logic [CNT_W-1:0] ones;
    logic             done;
    logic [1:0]       state_dbg;

    mux_scan_ctrl #(.WIDTH(WIDTH), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .w(w), .mask(mask), .hold(hold),
        .sel(sel), .f(f), .f_valid(f_valid), .busy(busy), .ones(ones), .done(done),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Each expected sample is packed as {sel, f}.
    logic [SEL_W:0] exp_q[$];
    int n_checks = 0;
    int n_pass = 0;

    typedef struct {
        logic [WIDTH-1:0] w;
        logic [WIDTH-1:0] mask;
        logic [63:0]      hold_pat;
        int               restart_cyc;
        int               exp_ones;
        int               exp_done;
        bit               idle_after;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Call this from an IDLE or DONE cycle. Start is driven in the current cycle, which is cycle 0.
    task automatic run_scan(input logic [WIDTH-1:0] vw, input logic [WIDTH-1:0] vm,
                            input logic [63:0] hold_pat, input int restart_cyc,
                            input int exp_ones_v, input int exp_done_cyc, input string tag);
        logic           seen_done;
        logic [SEL_W:0] e;
        w = vw; mask = vm; start = 1'b1; hold = 1'b0;
        exp_q.delete();
        for (int i = 0; i < WIDTH; i++)
            if (vm[i]) exp_q.push_back({SEL_W'(i), vw[i]});
        @(posedge clk); #1;
        start = 1'b0; w = ~vw; mask = ~vm;
        seen_done = 1'b0;
        for (int c = 1; c <= 60 && !seen_done; c++) begin
            hold  = hold_pat[c];
            start = (c == restart_cyc);
            #1;
            if (done) begin
                seen_done = 1'b1;
                check({tag, " done_cycle"}, c, exp_done_cyc);
                check({tag, " ones"}, 32'(ones), exp_ones_v);
                check({tag, " busy_in_done"}, 32'(busy), 0);
                check({tag, " f_valid_in_done"}, 32'(f_valid), 0);
                check({tag, " samples_left"}, exp_q.size(), 0);
            end else if (busy) begin
                if (f_valid) begin
                    if (exp_q.size() == 0) begin
                        check({tag, " extra_sample"}, 32'(f_valid), 0);
                    end else begin
                        e = exp_q.pop_front();
                        check({tag, " sel"}, 32'(sel), 32'(e[SEL_W:1]));
                        check({tag, " f"}, 32'(f), 32'(e[0]));
                    end
                end else begin
                    check({tag, " stall_without_hold"}, 32'(hold), 1);
                end
            end else begin
                check({tag, " busy_during_scan"}, 32'(busy), 1);
            end
            if (!seen_done) begin
                @(posedge clk); #1;
            end
        end
        hold = 1'b0; start = 1'b0;
        if (!seen_done) check({tag, " done_timeout"}, 32'(seen_done), 1);
    endtask

    task automatic check_idle(input int exp_ones_v, input string tag);
        @(posedge clk); #2;
        check({tag, " idle_done"}, 32'(done), 0);
        check({tag, " idle_busy"}, 32'(busy), 0);
        check({tag, " idle_f_valid"}, 32'(f_valid), 0);
        check({tag, " idle_f"}, 32'(f), 0);
        check({tag, " idle_sel"}, 32'(sel), 0);
        check({tag, " idle_ones_kept"}, 32'(ones), exp_ones_v);
    endtask

    vec_t vecs[7];

    initial begin
        int done_seen;
        logic [WIDTH-1:0] rw, rm;

        vecs[0] = '{16'h0001, 16'hFFFF, 64'h0, -1, 1, 17, 1'b1};
        vecs[1] = '{16'h0020, 16'h0024, 64'h0, -1, 1, 3, 1'b1};
        vecs[2] = '{16'hFFFF, 16'h0000, 64'h0, -1, 0, 1, 1'b1};
        vecs[3] = '{16'hFFFF, 16'h000F, 64'hC, 3, 4, 7, 1'b0};
        vecs[4] = '{16'h0003, 16'h0003, 64'h0, -1, 2, 3, 1'b1};
        vecs[5] = '{16'hAAAA, 16'hFF00, 64'h0, -1, 4, 9, 1'b1};
        vecs[6] = '{16'h1234, 16'h8001, 64'h0, -1, 0, 3, 1'b1};

        // Clock and reset.
        repeat (2) @(posedge clk);
        #1;
        check("reset sel", 32'(sel), 0);
        check("reset f", 32'(f), 0);
        check("reset f_valid", 32'(f_valid), 0);
        check("reset busy", 32'(busy), 0);
        check("reset ones", 32'(ones), 0);
        check("reset done", 32'(done), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven scans. Vector 3 chains into vector 4 from its DONE cycle.
        for (int v = 0; v < 7; v++) begin
            run_scan(vecs[v].w, vecs[v].mask, vecs[v].hold_pat, vecs[v].restart_cyc,
                     vecs[v].exp_ones, vecs[v].exp_done, $sformatf("vec%0d", v));
            if (vecs[v].idle_after) check_idle(vecs[v].exp_ones, $sformatf("vec%0d", v));
        end

        // Random scans without holds. The expected ones count and done cycle come from the spec rules.
        for (int r = 0; r < 6; r++) begin
            rw = WIDTH'($urandom_range(0, 65535));
            rm = WIDTH'($urandom_range(1, 65535));
            run_scan(rw, rm, 64'h0, -1, $countones(rw & rm), $countones(rm) + 1,
                     $sformatf("rand%0d", r));
            check_idle($countones(rw & rm), $sformatf("rand%0d", r));
        end

        // Apply reset mid-scan during cycle 5 of a full scan.
        w = 16'h0001; mask = 16'hFFFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("midrst pre sel", 32'(sel), 4);
        check("midrst pre busy", 32'(busy), 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrst sel", 32'(sel), 0);
        check("midrst f", 32'(f), 0);
        check("midrst f_valid", 32'(f_valid), 0);
        check("midrst busy", 32'(busy), 0);
        check("midrst ones", 32'(ones), 0);
        check("midrst done", 32'(done), 0);
        done_seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done || busy) done_seen++;
        end
        check("midrst no_activity_after", done_seen, 0);
        run_scan(16'h0001, 16'hFFFF, 64'h0, -1, 1, 17, "after_rst");
        check_idle(1, "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
